// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants for the round timer: FSM state encodings,
//               BCD digit width and the reload-to-BCD constant function.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // FSM state encodings (also presented on state_out)
  localparam logic [1:0] c_st_idle   = 2'b00;
  localparam logic [1:0] c_st_run    = 2'b01;
  localparam logic [1:0] c_st_paused = 2'b10;
  localparam logic [1:0] c_st_end    = 2'b11;

  localparam int BCD_W = 4;

  // Elaboration-time conversion of the reload value; the run-time BCD copy
  // is maintained by the borrow chain, never by division.
  function automatic logic [3*BCD_W-1:0] to_bcd(input logic [9:0] v);
    int n;
    n = int'(v);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : round_timer_if
// Description : Control/status bundle of the round timer.
//               master : drives start/pause/game_over, observes status
//               slave  : the timer itself
//               start, pause, game_over : game controls (1 bit each)
//               seg_out[9:0]   : binary countdown
//               bcd_out[11:0]  : {hundreds, tens, ones} of seg_out
//               endf, round_done, rounds[3:0], state_out[1:0] : status
// Revision    : 1.0 - initial release
// ============================================================================
interface round_timer_if;
  logic        start;
  logic        pause;
  logic        game_over;
  logic [9:0]  seg_out;
  logic        endf;
  logic        round_done;
  logic [11:0] bcd_out;
  logic [3:0]  rounds;
  logic [1:0]  state_out;

  modport master (
    output start, pause, game_over,
    input  seg_out, endf, round_done, bcd_out, rounds, state_out
  );

  modport slave (
    input  start, pause, game_over,
    output seg_out, endf, round_done, bcd_out, rounds, state_out
  );
endinterface
`default_nettype wire

// File: rtl/bcd_dec_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dec_digit
// Description : One BCD digit of a down-counter. Decrements when dec is
//               high, wrapping 0 -> 9 and raising borrow_out for the next
//               more-significant digit. load has priority over dec.
//               clk_1H, reset : clock / synchronous active-high reset
//               load, load_val: synchronous load
//               dec           : decrement enable (borrow in)
//               digit         : current digit value
//               borrow_out    : decrement request for the next digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_dec_digit
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] RESET_VAL = '0
) (
  input  logic             clk_1H,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] r_digit;

  always_ff @(posedge clk_1H) begin
    if (reset) begin
      r_digit <= RESET_VAL;
    end else if (load) begin
      r_digit <= load_val;
    end else if (dec) begin
      r_digit <= (r_digit == '0) ? BCD_W'(9) : r_digit - BCD_W'(1);
    end
  end

  assign digit      = r_digit;
  assign borrow_out = dec && (r_digit == '0);

endmodule
`default_nettype wire

// File: rtl/round_timer.sv
`default_nettype none
// ============================================================================
// Module      : round_timer
// Description : Game round timer. Counts ROUND_SECS down to 0 once per
//               round (one zero cycle per round), counts completed rounds
//               and raises endf after MAX_ROUNDS rounds or on game_over.
//               A BCD copy of the countdown is kept in lock-step.
//               clk_1H : 1 Hz game tick
//               reset  : synchronous, active-high
//               bus    : round_timer_if slave (controls and status)
// Revision    : 1.0 - initial release
// ============================================================================
module round_timer
  import timer_pkg::*;
#(
  parameter logic [9:0] ROUND_SECS = 10'd60,
  parameter logic [3:0] MAX_ROUNDS = 4'd9
) (
  input  logic         clk_1H,
  input  logic         reset,
  round_timer_if.slave bus
);

  localparam logic [3*BCD_W-1:0] c_reload_bcd = to_bcd(ROUND_SECS);

  logic [1:0] r_state, w_state;
  logic [9:0] r_seg, w_seg;
  logic [3:0] r_rounds, w_rounds;
  logic       r_endf, w_endf;
  logic       r_round_done, w_round_done;
  logic       w_dec;   // binary counter decrements this edge
  logic       w_load;  // counter reloads to ROUND_SECS this edge

  always_comb begin
    w_state      = r_state;
    w_seg        = r_seg;
    w_rounds     = r_rounds;
    w_endf       = r_endf;
    w_round_done = 1'b0;
    w_dec        = 1'b0;
    w_load       = 1'b0;

    case (r_state)
      c_st_idle: begin
        w_seg    = ROUND_SECS;
        w_rounds = '0;
        w_load   = 1'b1;
        if (bus.start) w_state = c_st_run;
      end

      c_st_run: begin
        if (bus.game_over) begin
          w_state = c_st_end;
          w_endf  = 1'b1;
        end else if (r_seg == '0) begin
          // Zero cycle: pause is deliberately not looked at here so the
          // downstream advance pulse is always exactly one clock wide.
          w_rounds = r_rounds + 4'd1;
          if (w_rounds == MAX_ROUNDS) begin
            w_state = c_st_end;
            w_endf  = 1'b1;
          end else begin
            w_seg  = ROUND_SECS;
            w_load = 1'b1;
          end
        end else if (bus.pause) begin
          w_state = c_st_paused;
        end else begin
          w_seg        = r_seg - 10'd1;
          w_dec        = 1'b1;
          w_round_done = (r_seg == 10'd1);
        end
      end

      c_st_paused: begin
        if (bus.game_over) begin
          w_state = c_st_end;
          w_endf  = 1'b1;
        end else if (!bus.pause) begin
          // Release resumes counting on the same edge, so the held value
          // is followed directly by the next count.
          w_state = c_st_run;
          if (r_seg != '0) begin
            w_seg        = r_seg - 10'd1;
            w_dec        = 1'b1;
            w_round_done = (r_seg == 10'd1);
          end
        end
      end

      c_st_end: begin
        if (bus.start) begin
          w_state  = c_st_run;
          w_seg    = ROUND_SECS;
          w_rounds = '0;
          w_endf   = 1'b0;
          w_load   = 1'b1;
        end
      end

      default: w_state = c_st_idle;
    endcase
  end

  always_ff @(posedge clk_1H) begin
    if (reset) begin
      r_state      <= c_st_idle;
      r_seg        <= ROUND_SECS;
      r_rounds     <= '0;
      r_endf       <= 1'b0;
      r_round_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_seg        <= w_seg;
      r_rounds     <= w_rounds;
      r_endf       <= w_endf;
      r_round_done <= w_round_done;
    end
  end

  // BCD shadow counter: ones digit decrements with the binary counter,
  // each borrow ripples to the next digit.
  logic [3*BCD_W-1:0] w_bcd;
  logic [2:0]         w_borrow_out;
  logic [2:0]         w_borrow_in;
  logic               w_borrow_unused;

  assign w_borrow_in     = {w_borrow_out[1:0], w_dec};
  assign w_borrow_unused = w_borrow_out[2];

  generate
    for (genvar i = 0; i < 3; i++) begin : g_digit
      bcd_dec_digit #(
        .RESET_VAL (c_reload_bcd[BCD_W*i +: BCD_W])
      ) u_digit (
        .clk_1H     (clk_1H),
        .reset      (reset),
        .load       (w_load),
        .load_val   (c_reload_bcd[BCD_W*i +: BCD_W]),
        .dec        (w_borrow_in[i]),
        .digit      (w_bcd[BCD_W*i +: BCD_W]),
        .borrow_out (w_borrow_out[i])
      );
    end
  endgenerate

  assign bus.seg_out    = r_seg;
  assign bus.endf       = r_endf;
  assign bus.round_done = r_round_done;
  assign bus.bcd_out    = w_bcd;
  assign bus.rounds     = r_rounds;
  assign bus.state_out  = r_state;

endmodule
`default_nettype wire
